// File: rtl/fb_pkg.sv
// Shared definitions for the frame-buffer memory arbiter: FSM encodings,
// signal polarity and VGA frame geometry.
package fb_pkg;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WR      = 2'd1;
  localparam logic [1:0] S_RD_CMD  = 2'd2;
  localparam logic [1:0] S_RD_WAIT = 2'd3;

  localparam logic ASSERT   = 1'b1;
  localparam logic DEASSERT = 1'b0;

  localparam int FRAME_H        = 640;
  localparam int FRAME_V        = 480;
  localparam int FB_FRAME_WORDS = FRAME_H * FRAME_V;

  typedef enum logic {
    GRANT_RD = 1'b0,
    GRANT_WR = 1'b1
  } grant_t;

  // Offset must be able to hold FRAME_WORDS itself before it wraps.
  function automatic int offset_width(input int frame_words);
    return $clog2(frame_words + 1);
  endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Per-stream frame offset: advances one burst at a time, wraps at the end of
// the frame with a one-cycle frame_done, and restarts on frame_start.
module fb_addr_gen
  import fb_pkg::*;
#(
  parameter int BURST_LEN   = 8,
  parameter int FRAME_WORDS = FB_FRAME_WORDS,
  parameter int OFF_W       = offset_width(FRAME_WORDS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             burst_done,
  input  logic             frame_start,
  output logic [OFF_W-1:0] offset,
  output logic             frame_done
);

  localparam logic [OFF_W:0] STEP      = (OFF_W+1)'(BURST_LEN);
  localparam logic [OFF_W:0] FRAME_END = (OFF_W+1)'(FRAME_WORDS);

  logic [OFF_W:0] next_sum;
  logic           wrap;

  always_comb begin
    next_sum = {1'b0, offset} + STEP;
    wrap     = (next_sum == FRAME_END);
  end

  // The last burst still reports frame_done even when frame_start lands on it.
  assign frame_done = (burst_done && wrap) ? ASSERT : DEASSERT;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      offset <= '0;
    end else if (frame_start) begin
      offset <= '0;
    end else if (burst_done) begin
      offset <= wrap ? '0 : next_sum[OFF_W-1:0];
    end
  end

endmodule

// File: rtl/fb_mem_arbiter.sv
// Shares one Avalon-MM frame-buffer port between the camera write stream and
// the display read stream, one whole burst at a time, round-robin on contention.
module fb_mem_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W      = 26,
  parameter int BURST_LEN   = 8,
  parameter int FRAME_WORDS = FB_FRAME_WORDS,
  parameter int FB0_BASE    = 0,
  parameter int FB1_BASE    = 524288
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_req,
  input  logic              rd_req,
  input  logic              wr_buf_sel,
  input  logic              rd_buf_sel,
  input  logic              wr_frame_start,
  input  logic              rd_frame_start,
  input  logic              avl_ready,
  input  logic              avl_rdata_valid,
  output logic [ADDR_W-1:0] avl_addr,
  output logic [6:0]        avl_burstcount,
  output logic              avl_write,
  output logic              avl_read,
  output logic              cam_rdreq,
  output logic              adv_wrreq,
  output logic              wr_frame_done,
  output logic              rd_frame_done,
  output logic              busy
);

  localparam int OFF_W  = offset_width(FRAME_WORDS);
  localparam int BEAT_W = $clog2(BURST_LEN);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [BEAT_W-1:0] ONE_BEAT  = BEAT_W'(1);
  localparam logic [ADDR_W-1:0] FB0_ADDR  = ADDR_W'(FB0_BASE);
  localparam logic [ADDR_W-1:0] FB1_ADDR  = ADDR_W'(FB1_BASE);
  localparam logic [6:0]        BURST_CNT = 7'(BURST_LEN);

  if (BURST_LEN < 2 || BURST_LEN > 64 || (BURST_LEN & (BURST_LEN - 1)) != 0) begin : g_bad_burst
    $error("BURST_LEN must be a power of two between 2 and 64");
  end
  if (FRAME_WORDS % BURST_LEN != 0) begin : g_bad_frame
    $error("FRAME_WORDS must be a multiple of BURST_LEN");
  end

  logic [1:0]        state;
  logic [BEAT_W-1:0] beat_cnt;
  grant_t            last_grant;

  logic [OFF_W-1:0]  wr_offset;
  logic [OFF_W-1:0]  rd_offset;
  logic [ADDR_W-1:0] wr_start_addr;
  logic [ADDR_W-1:0] rd_start_addr;

  logic wr_beat;
  logic rd_beat;
  logic last_beat;
  logic wr_burst_done;
  logic rd_burst_done;
  logic grant_wr;
  logic grant_rd;

  // NOTE: every signal gets a default at the top of the block so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_beat       = (state == S_WR) && avl_ready;
    rd_beat       = (state == S_RD_WAIT) && avl_rdata_valid;
    last_beat     = (beat_cnt == LAST_BEAT);
    wr_burst_done = wr_beat && last_beat;
    rd_burst_done = rd_beat && last_beat;

    grant_rd = DEASSERT;
    grant_wr = DEASSERT;
    if (state == S_IDLE) begin
      // Read wins when alone or when write was served last.
      if (rd_req && (!wr_req || last_grant == GRANT_WR)) begin
        grant_rd = ASSERT;
      end else if (wr_req) begin
        grant_wr = ASSERT;
      end
    end

    wr_start_addr = (wr_buf_sel ? FB1_ADDR : FB0_ADDR) + ADDR_W'(wr_offset);
    rd_start_addr = (rd_buf_sel ? FB1_ADDR : FB0_ADDR) + ADDR_W'(rd_offset);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      beat_cnt   <= '0;
      last_grant <= GRANT_WR;
      avl_addr   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          beat_cnt <= '0;
          if (grant_rd) begin
            state      <= S_RD_CMD;
            avl_addr   <= rd_start_addr;
            last_grant <= GRANT_RD;
          end else if (grant_wr) begin
            state      <= S_WR;
            avl_addr   <= wr_start_addr;
            last_grant <= GRANT_WR;
          end
        end
        S_WR: begin
          if (wr_beat) begin
            beat_cnt <= beat_cnt + ONE_BEAT;
            if (last_beat) state <= S_IDLE;
          end
        end
        S_RD_CMD: begin
          if (avl_ready) state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (rd_beat) begin
            beat_cnt <= beat_cnt + ONE_BEAT;
            if (last_beat) state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  fb_addr_gen #(
    .BURST_LEN  (BURST_LEN),
    .FRAME_WORDS(FRAME_WORDS),
    .OFF_W      (OFF_W)
  ) u_wr_addr (
    .clk        (clk),
    .reset      (reset),
    .burst_done (wr_burst_done),
    .frame_start(wr_frame_start),
    .offset     (wr_offset),
    .frame_done (wr_frame_done)
  );

  fb_addr_gen #(
    .BURST_LEN  (BURST_LEN),
    .FRAME_WORDS(FRAME_WORDS),
    .OFF_W      (OFF_W)
  ) u_rd_addr (
    .clk        (clk),
    .reset      (reset),
    .burst_done (rd_burst_done),
    .frame_start(rd_frame_start),
    .offset     (rd_offset),
    .frame_done (rd_frame_done)
  );

  assign avl_write      = (state == S_WR);
  assign avl_read       = (state == S_RD_CMD);
  assign avl_burstcount = (avl_write || avl_read) ? BURST_CNT : '0;
  assign cam_rdreq      = wr_beat;
  assign adv_wrreq      = rd_beat;
  assign busy           = (state != S_IDLE);

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Directed bench for fb_mem_arbiter: expected bursts are queued as stimulus is
// set up and checked as the arbiter issues them.
module tb_fb_mem_arbiter;

  localparam int AW  = 26;
  localparam int BL  = 8;
  localparam int FW  = 80;      // small frame so the wrap is reached quickly
  localparam int FB1 = 524288;

  typedef struct {
    bit is_wr;
    int addr;
  } burst_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr_req = 1'b0, rd_req = 1'b0;
  logic          wr_buf_sel = 1'b0, rd_buf_sel = 1'b0;
  logic          wr_frame_start = 1'b0, rd_frame_start = 1'b0;
  logic          avl_ready = 1'b0, avl_rdata_valid = 1'b0;
  logic [AW-1:0] avl_addr;
  logic [6:0]    avl_burstcount;
  logic          avl_write, avl_read, cam_rdreq, adv_wrreq;
  logic          wr_frame_done, rd_frame_done, busy;
  logic [39:0]   outs;

  int checks = 0;
  int failures = 0;
  burst_t exp_q[$];

  int            idle_cnt;
  logic [AW-1:0] start_addr;
  int            r_pops, r_done, r_done_beat, r_bad, r_moves, r_cycles;

  fb_mem_arbiter #(
    .ADDR_W(AW), .BURST_LEN(BL), .FRAME_WORDS(FW), .FB0_BASE(0), .FB1_BASE(FB1)
  ) dut (
    .clk(clk), .reset(reset),
    .wr_req(wr_req), .rd_req(rd_req),
    .wr_buf_sel(wr_buf_sel), .rd_buf_sel(rd_buf_sel),
    .wr_frame_start(wr_frame_start), .rd_frame_start(rd_frame_start),
    .avl_ready(avl_ready), .avl_rdata_valid(avl_rdata_valid),
    .avl_addr(avl_addr), .avl_burstcount(avl_burstcount),
    .avl_write(avl_write), .avl_read(avl_read),
    .cam_rdreq(cam_rdreq), .adv_wrreq(adv_wrreq),
    .wr_frame_done(wr_frame_done), .rd_frame_done(rd_frame_done),
    .busy(busy)
  );

  assign outs = {avl_addr, avl_burstcount, avl_write, avl_read, cam_rdreq,
                 adv_wrreq, wr_frame_done, rd_frame_done, busy};

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input bit is_wr, input int addr);
    burst_t e;
    e.is_wr = is_wr;
    e.addr  = addr;
    exp_q.push_back(e);
  endtask

  // Waits (bounded) for the next burst and checks it against the scoreboard.
  task automatic wait_start(input string tag);
    burst_t e;
    int n;
    n = 0;
    #1;
    while (!(avl_write || avl_read) && n < 40) begin
      next_cycle();
      #1;
      n++;
    end
    idle_cnt = n;
    check({tag, "_start_seen"}, int'(avl_write | avl_read), 1);
    check({tag, "_idle_gap"}, idle_cnt, 1);
    check({tag, "_sb_pending"}, int'(exp_q.size() != 0), 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_kind"}, int'(avl_write), int'(e.is_wr));
      check({tag, "_addr"}, int'(avl_addr), e.addr);
    end
    check({tag, "_burstcount"}, int'(avl_burstcount), BL);
    start_addr = avl_addr;
  endtask

  task automatic run_write(input logic [3:0] pat, input bit fs_last);
    int acc;
    int n;
    acc = 0;
    n = 0;
    r_pops = 0; r_done = 0; r_done_beat = -1; r_bad = 0; r_moves = 0;
    while (acc < BL && n < 64) begin
      avl_ready      = pat[n % 4];
      wr_frame_start = fs_last && avl_ready && (acc == BL - 1);
      #1;
      if (!avl_write) r_bad++;
      if (avl_addr !== start_addr) r_moves++;
      if (cam_rdreq) r_pops++;
      if (cam_rdreq !== avl_ready) r_bad++;
      if (wr_frame_done) begin r_done++; r_done_beat = acc; end
      if (avl_ready) acc++;
      n++;
      next_cycle();
    end
    avl_ready      = 1'b0;
    wr_frame_start = 1'b0;
    r_cycles       = n;
  endtask

  task automatic run_read(input int cmd_stall, input int gap, input bit fs_last);
    int beats;
    int n;
    r_pops = 0; r_done = 0; r_done_beat = -1; r_bad = 0; r_moves = 0;
    // Stray data-valid while the command is still pending must be ignored.
    for (int k = 0; k < cmd_stall; k++) begin
      avl_ready       = 1'b0;
      avl_rdata_valid = 1'b1;
      #1;
      if (!avl_read) r_bad++;
      if (adv_wrreq) r_bad++;
      next_cycle();
    end
    avl_rdata_valid = 1'b0;
    avl_ready       = 1'b1;
    #1;
    if (!avl_read) r_bad++;
    next_cycle();
    avl_ready = 1'b0;
    beats = 0;
    n = 0;
    while (beats < BL && n < 64) begin
      avl_rdata_valid = (gap == 0) || (n % 2 == 1);
      rd_frame_start  = fs_last && avl_rdata_valid && (beats == BL - 1);
      #1;
      if (avl_read) r_bad++;
      if (avl_addr !== start_addr) r_moves++;
      if (adv_wrreq) r_pops++;
      if (adv_wrreq !== avl_rdata_valid) r_bad++;
      if (rd_frame_done) begin r_done++; r_done_beat = beats; end
      if (avl_rdata_valid) beats++;
      n++;
      next_cycle();
    end
    avl_rdata_valid = 1'b0;
    rd_frame_start  = 1'b0;
    r_cycles        = n;
  endtask

  task automatic check_burst(input string tag, input bit exp_done);
    check({tag, "_pops"}, r_pops, BL);
    check({tag, "_protocol"}, r_bad, 0);
    check({tag, "_addr_hold"}, r_moves, 0);
    check({tag, "_frame_done_cnt"}, r_done, exp_done ? 1 : 0);
    check({tag, "_frame_done_beat"}, r_done_beat, exp_done ? BL - 1 : -1);
  endtask

  initial begin
    int cnt;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs_zero", int'(|outs), 0);
    reset = 1'b1;

    // 1: write only, FB0, addresses 0, 8, 16; request dropped mid-burst
    wr_req = 1'b1;
    wr_buf_sel = 1'b0;
    for (int b = 0; b < 3; b++) push_exp(1'b1, b * BL);
    for (int b = 0; b < 3; b++) begin
      wait_start($sformatf("wronly%0d", b));
      if (b == 2) wr_req = 1'b0;
      run_write(4'b1111, 1'b0);
      check_burst($sformatf("wronly%0d", b), 1'b0);
    end
    next_cycle();
    next_cycle();
    #1;
    check("wronly_idle_after_drop", int'(busy), 0);

    // 3: backpressure 1,0,0,1 on a write to FB1; buf_sel flips mid-burst
    next_cycle();
    wr_buf_sel = 1'b1;
    wr_req = 1'b1;
    push_exp(1'b1, FB1 + 24);
    wait_start("bp");
    wr_req = 1'b0;
    wr_buf_sel = 1'b0;
    run_write(4'b1001, 1'b0);
    check_burst("bp", 1'b0);
    check("bp_cycles", r_cycles, 16);

    // 2: contention alternates R, W, R, W
    rd_buf_sel = 1'b1;
    wr_buf_sel = 1'b0;
    rd_req = 1'b1;
    wr_req = 1'b1;
    push_exp(1'b0, FB1 + 0);
    push_exp(1'b1, 32);
    push_exp(1'b0, FB1 + 8);
    push_exp(1'b1, 40);
    for (int b = 0; b < 4; b++) begin
      wait_start($sformatf("rr%0d", b));
      if (b == 3) begin rd_req = 1'b0; wr_req = 1'b0; end
      if (b % 2 == 0) run_read(0, 0, 1'b0);
      else run_write(4'b1111, 1'b0);
      check_burst($sformatf("rr%0d", b), 1'b0);
    end

    // 4: read frame wrap on FB1, offsets 16..72 then back to 0
    rd_req = 1'b1;
    for (int b = 0; b < 8; b++) push_exp(1'b0, FB1 + 16 + b * BL);
    push_exp(1'b0, FB1 + 0);
    for (int b = 0; b < 9; b++) begin
      wait_start($sformatf("rwrap%0d", b));
      if (b == 8) rd_req = 1'b0;
      run_read(b % 3, b % 2, 1'b0);
      check_burst($sformatf("rwrap%0d", b), b == 7);
    end

    // 5: rd_frame_start on the completion cycle of a mid-frame burst
    rd_req = 1'b1;
    push_exp(1'b0, FB1 + 8);
    push_exp(1'b0, FB1 + 0);
    wait_start("coll0");
    run_read(0, 0, 1'b1);
    check_burst("coll0", 1'b0);
    wait_start("coll1");
    rd_req = 1'b0;
    run_read(1, 0, 1'b0);
    check_burst("coll1", 1'b0);

    // 6: reset during S_RD_WAIT after three beats
    rd_req = 1'b1;
    push_exp(1'b0, FB1 + 8);
    wait_start("rstrd");
    rd_req = 1'b0;
    avl_ready = 1'b1;
    #1;
    next_cycle();
    avl_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      avl_rdata_valid = 1'b1;
      #1;
      next_cycle();
    end
    avl_rdata_valid = 1'b1;
    reset = 1'b0;
    #1;
    check("rstrd_outputs_zero", int'(|outs), 0);
    cnt = 0;
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      #1;
      if (adv_wrreq || busy) cnt++;
    end
    check("rstrd_no_late_push", cnt, 0);
    avl_rdata_valid = 1'b0;
    next_cycle();
    reset = 1'b1;
    wr_req = 1'b1;
    rd_req = 1'b1;
    wr_buf_sel = 1'b0;
    rd_buf_sel = 1'b1;
    push_exp(1'b0, FB1 + 0);
    push_exp(1'b1, 0);
    for (int b = 0; b < 2; b++) begin
      wait_start($sformatf("postrst%0d", b));
      if (b == 1) begin rd_req = 1'b0; wr_req = 1'b0; end
      if (b == 0) run_read(0, 0, 1'b0);
      else run_write(4'b1111, 1'b0);
      check_burst($sformatf("postrst%0d", b), 1'b0);
    end

    // Write frame wrap on FB1 with wr_frame_start on the final completion
    wr_req = 1'b1;
    wr_buf_sel = 1'b1;
    for (int b = 0; b < 9; b++) push_exp(1'b1, FB1 + 8 + b * BL);
    push_exp(1'b1, FB1 + 0);
    for (int b = 0; b < 10; b++) begin
      wait_start($sformatf("wwrap%0d", b));
      if (b == 9) wr_req = 1'b0;
      run_write((b == 4) ? 4'b1001 : 4'b1111, b == 8);
      check_burst($sformatf("wwrap%0d", b), b == 8);
    end
    check("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
